demux_1to2_d: RTL and testbench

Registered 1-to-2 demultiplexer for a parameterizable-width data word. Each cycle, input word i is steered to output o0 (sel=0) or o1 (sel=1). The unselected output is forced to zero. Used as a small routing element in datapaths that need a clean, registered fan-out to one of two consumers.

---
 rtl/demux_1to2_d.sv | 40 ++++
 tb/tb_demux_1to2_d.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_d.sv
// demux_1to2_d: registered 1-to-2 demux; the unselected branch and idle cycles drive all-zeros
module demux_1to2_d #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] i,
   input  logic             sel,
   input  logic             in_vld,
   output logic [width-1:0] o0,
   output logic [width-1:0] o1,
   output logic             o0_vld,
   output logic             o1_vld
);
   logic [width-1:0] o0_d, o0_q, o1_d, o1_q;
   logic             o0_vld_d, o0_vld_q, o1_vld_d, o1_vld_q;
   always_comb begin
      o0_vld_d = in_vld & ~sel;
      o1_vld_d = in_vld & sel;
      o0_d     = o0_vld_d ? i : '0;
      o1_d     = o1_vld_d ? i : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o0_q     <= '0;
         o1_q     <= '0;
         o0_vld_q <= 1'b0;
         o1_vld_q <= 1'b0;
      end else begin
         o0_q     <= o0_d;
         o1_q     <= o1_d;
         o0_vld_q <= o0_vld_d;
         o1_vld_q <= o1_vld_d;
      end
   end
   assign o0     = o0_q;
   assign o1     = o1_q;
   assign o0_vld = o0_vld_q;
   assign o1_vld = o1_vld_q;
endmodule

// File: tb/tb_demux_1to2_d.sv
// tb_demux_1to2_d: vector table plus scoreboard for width 4, directed and random traffic for width 8
module tb_demux_1to2_d;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] i4 = '0, o0_4, o1_4;
   logic       sel4 = 1'b0, vld4 = 1'b0, o0v4, o1v4;
   logic [7:0] i8 = '0, o0_8, o1_8;
   logic       sel8 = 1'b0, vld8 = 1'b0, o0v8, o1v8;
   typedef struct packed {
      logic [7:0] o0;
      logic [7:0] o1;
      logic       v0;
      logic       v1;
   } exp_t;
   typedef struct {
      logic       v;
      logic       s;
      logic [3:0] d;
      logic [3:0] e0;
      logic [3:0] e1;
      logic       ev0;
      logic       ev1;
   } vec_t;
   exp_t sbq[$];
   vec_t vecs[18];
   int   n_cmp = 0, n_bad = 0;
   localparam exp_t ZERO = '0;

   demux_1to2_d #(.width(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .i(i4), .sel(sel4), .in_vld(vld4),
      .o0(o0_4), .o1(o1_4), .o0_vld(o0v4), .o1_vld(o1v4)
   );
   demux_1to2_d #(.width(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .i(i8), .sel(sel8), .in_vld(vld8),
      .o0(o0_8), .o1(o1_8), .o0_vld(o0v8), .o1_vld(o1v8)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic v, input logic s, input logic [7:0] d);
      exp_t e;
      e.v0 = v && !s;
      e.v1 = v && s;
      e.o0 = e.v0 ? d : 8'h00;
      e.o1 = e.v1 ? d : 8'h00;
      return e;
   endfunction

   function automatic exp_t act4();
      return '{o0: {4'h0, o0_4}, o1: {4'h0, o1_4}, v0: o0v4, v1: o1v4};
   endfunction

   function automatic exp_t act8();
      return '{o0: o0_8, o1: o1_8, v0: o0v8, v1: o1v8};
   endfunction

   task automatic check(input string name, input exp_t act);
      exp_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %h", name, act);
         return;
      end
      e = sbq.pop_front();
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got o0=%h o1=%h v0=%b v1=%b required o0=%h o1=%h v0=%b v1=%b",
                  name, act.o0, act.o1, act.v0, act.v1, e.o0, e.o1, e.v0, e.v1);
      end
   endtask

   task automatic flag_x(input logic v, input logic s);
      if ($isunknown(v) || (v !== 1'b0 && $isunknown(s))) begin
         n_bad++;
         $display("FAIL illegal_input: in_vld=%b sel=%b", v, s);
      end
   endtask

   task automatic drive4(input string name, input logic v, input logic s, input logic [3:0] d, input exp_t e);
      @(negedge clk);
      vld4 = v; sel4 = s; i4 = d;
      flag_x(v, s);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check(name, act4());
   endtask

   task automatic drive8(input string name, input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      vld8 = v; sel8 = s; i8 = d;
      flag_x(v, s);
      sbq.push_back(model(v, s, d));
      @(posedge clk);
      #1;
      check(name, act8());
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 4'hA, 4'hA, 4'h0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'hB, 4'hB, 4'h0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'hC, 4'hC, 4'h0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'hD, 4'hD, 4'h0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 4'hA, 4'h0, 4'hA, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 4'hB, 4'h0, 4'hB, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 4'hC, 4'h0, 4'hC, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 4'hD, 4'h0, 4'hD, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 4'hA, 4'hA, 4'h0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 4'hB, 4'h0, 4'hB, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 4'hC, 4'hC, 4'h0, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 4'hD, 4'h0, 4'hD, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0};

      #1;
      sbq.push_back(ZERO);
      check("reset_init4", act4());
      sbq.push_back(ZERO);
      check("reset_init8", act8());
      for (int k = 0; k < 3; k++) drive4("reset_hold", 1'b1, 1'b0, 4'hF, ZERO);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 18; k++)
         drive4($sformatf("vec%0d", k), vecs[k].v, vecs[k].s, vecs[k].d,
                '{o0: {4'h0, vecs[k].e0}, o1: {4'h0, vecs[k].e1}, v0: vecs[k].ev0, v1: vecs[k].ev1});

      drive4("pre_async", 1'b1, 1'b0, 4'hA, '{o0: 8'h0A, o1: 8'h00, v0: 1'b1, v1: 1'b0});
      #2;
      rst_n = 1'b0;
      #1;
      sbq.push_back(ZERO);
      check("async_clear", act4());
      drive4("reset_discard", 1'b1, 1'b1, 4'h7, ZERO);
      @(negedge clk);
      rst_n = 1'b1;
      drive4("post_reset", 1'b1, 1'b1, 4'h6, '{o0: 8'h00, o1: 8'h06, v0: 1'b0, v1: 1'b1});
      drive4("idle_after", 1'b0, 1'b0, 4'h6, ZERO);

      sbq.push_back('{o0: 8'h00, o1: 8'h5A, v0: 1'b0, v1: 1'b1});
      @(negedge clk);
      vld8 = 1'b1; sel8 = 1'b1; i8 = 8'h5A;
      @(posedge clk);
      #1;
      check("w8_5a", act8());

      for (int k = 0; k < 1000; k++) begin
         drive8("rand8", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 8'($urandom));
         n_cmp++;
         if (o0v8 && o1v8) begin
            n_bad++;
            $display("FAIL strobe_excl: o0_vld=%b o1_vld=%b required not both 1", o0v8, o1v8);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end
endmodule
